gcd_lcm_coproc: RTL and testbench

Fixed-function GCD/LCM coprocessor that answers the processor's coprocessor command interface. The processor core issues a one-cycle `start` with a packed operand word. This block computes either GCD (binary/Stein algorithm) or LCM (computed as `(A / gcd) * B`) over several cycles. It then returns the result with a one-cycle `done` pulse and a held `ans` word. It sits beside the data memory on the store-data path and is the responder end of the processor's start/data/done/answer handshake.

---
 rtl/gcd_lcm_coproc.sv | 182 ++++++++++++++++++
 tb/tb_gcd_lcm_coproc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm_coproc.sv
// GCD/LCM coprocessor: binary (Stein) GCD, then LCM as (A / gcd) * B using
// a 16-cycle restoring divider followed by a 16-cycle shift-add multiplier.
module gcd_lcm_coproc (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] ans
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStrip = 3'd1;
    localparam logic [2:0] StLoop  = 3'd2;
    localparam logic [2:0] StFix   = 3'd3;
    localparam logic [2:0] StDiv   = 3'd4;
    localparam logic [2:0] StMul   = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  k_q, k_d;
    logic [15:0] g_q, g_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [31:0] prod_q, prod_d;
    logic [31:0] mcand_q, mcand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ans_q, ans_d;

    logic [15:0] g_calc;
    logic [16:0] rem_shift;
    logic [16:0] rem_sub;
    logic [31:0] prod_sum;

    assign g_calc    = a_q << k_q;
    assign rem_shift = {rem_q, quo_q[15]};
    assign rem_sub   = rem_shift - {1'b0, g_q};
    assign prod_sum  = prod_q + (quo_q[0] ? mcand_q : 32'd0);

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign ans  = ans_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        g_d     = g_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        ans_d   = ans_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d  = op;
                    opa_d = wdata[31:16];
                    opb_d = wdata[15:0];
                    a_d   = wdata[31:16];
                    b_d   = wdata[15:0];
                    k_d   = 5'd0;
                    if (wdata[31:16] == 16'd0 || wdata[15:0] == 16'd0) begin
                        // gcd(0,x) = x, lcm with a zero operand = 0
                        ans_d   = op ? 32'd0 : {16'd0, wdata[31:16] | wdata[15:0]};
                        state_d = StDone;
                    end else begin
                        state_d = StStrip;
                    end
                end
            end
            StStrip: begin
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 5'd1;
                end else begin
                    state_d = StLoop;
                end
            end
            StLoop: begin
                if (a_q == b_q) begin
                    state_d = StFix;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            StFix: begin
                if (!op_q) begin
                    ans_d   = {16'd0, g_calc};
                    state_d = StDone;
                end else begin
                    g_d     = g_calc;
                    quo_d   = opa_q;
                    rem_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                if (rem_shift >= {1'b0, g_q}) begin
                    rem_d = rem_sub[15:0];
                    quo_d = {quo_q[14:0], 1'b1};
                end else begin
                    rem_d = rem_shift[15:0];
                    quo_d = {quo_q[14:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    prod_d  = 32'd0;
                    mcand_d = {16'd0, opb_q};
                    state_d = StMul;
                end
            end
            StMul: begin
                prod_d  = prod_sum;
                mcand_d = mcand_q << 1;
                quo_d   = quo_q >> 1;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    ans_d   = prod_sum;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            opa_q   <= 16'd0;
            opb_q   <= 16'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            k_q     <= 5'd0;
            g_q     <= 16'd0;
            rem_q   <= 16'd0;
            quo_q   <= 16'd0;
            prod_q  <= 32'd0;
            mcand_q <= 32'd0;
            cnt_q   <= 4'd0;
            ans_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            g_q     <= g_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            ans_q   <= ans_d;
        end
    end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Directed-vector bench for gcd_lcm_coproc: table of commands with hand-computed
// answers and done latencies, plus reset-abort and held-start sequences.
module tb_gcd_lcm_coproc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] ans;

    int checks = 0;
    int errors = 0;

    gcd_lcm_coproc dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .ans   (ans)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] wdata;
        logic [31:0] exp_ans;
        int          lat;
        bit          exact;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one command at a negedge; return done cycle (edge of accept = cycle 0).
    task automatic run_cmd(input logic o, input logic [31:0] w, output int lat,
                           output logic [31:0] got, output bit busy_ok,
                           output logic [31:0] ans_c1);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        wdata = w;
        @(negedge clk);
        start   = 1'b0;
        wdata   = $urandom;
        op      = 1'($urandom_range(0, 1));
        lat     = -1;
        busy_ok = 1'b1;
        ans_c1  = ans;
        got     = ans;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c;
                got = ans;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] got;
        logic [31:0] ans_c1;
        logic [31:0] prev;
        bit          busy_ok;
        int          dones;
        logic [31:0] first_ans;
        int          cyc;

        vecs[0]  = '{1'b0, 32'h000C_0012, 32'd6,          7,  1'b1};
        vecs[1]  = '{1'b1, 32'h000C_0012, 32'd36,         39, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_0009, 32'd9,          1,  1'b1};
        vecs[3]  = '{1'b1, 32'h0000_0009, 32'd0,          1,  1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'd0,          1,  1'b1};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFE, 32'hFFFD_0002, 85, 1'b0};
        vecs[6]  = '{1'b0, 32'hFFFF_0001, 32'd1,          53, 1'b0};
        vecs[7]  = '{1'b0, 32'h8000_8000, 32'd32768,      53, 1'b0};
        vecs[8]  = '{1'b1, 32'h0009_0000, 32'd0,          1,  1'b1};
        vecs[9]  = '{1'b0, 32'h0009_0000, 32'd9,          1,  1'b1};
        vecs[10] = '{1'b1, 32'h0015_0006, 32'd42,         85, 1'b0};
        vecs[11] = '{1'b0, 32'h0030_0024, 32'd12,         53, 1'b0};
        vecs[12] = '{1'b1, 32'h0007_000B, 32'd77,         85, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ans", ans, 32'd0);

        prev = 32'd0;
        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].op, vecs[i].wdata, lat, got, busy_ok, ans_c1);
            check($sformatf("vec%0d_ans", i), got, vecs[i].exp_ans);
            if (vecs[i].exact)
                check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            else
                check($sformatf("vec%0d_latency_bound", i),
                      {31'd0, (lat >= 1 && lat <= vecs[i].lat)}, 32'd1);
            check($sformatf("vec%0d_busy_while_running", i), {31'd0, busy_ok}, 32'd1);
            if (vecs[i].wdata[31:16] != 16'd0 && vecs[i].wdata[15:0] != 16'd0)
                check($sformatf("vec%0d_ans_held_cycle1", i), ans_c1, prev);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d_ans_held_after", i), ans, vecs[i].exp_ans);
            prev = vecs[i].exp_ans;
        end

        // Reset in the middle of a long LCM must abort with no stale done.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        wdata = 32'hFFFF_FFFE;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("midop_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_ans", ans, 32'd0);
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_stale_done", dones, 0);
        run_cmd(1'b0, 32'h000C_0012, lat, got, busy_ok, ans_c1);
        check("post_reset_gcd_ans", got, 32'd6);
        check("post_reset_gcd_latency", lat, 7);

        // Start held high with changing operands through a busy LCM.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        wdata = 32'h000C_0012;
        dones = 0;
        first_ans = 32'd0;
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            cyc = c;
            if (done) begin
                dones++;
                first_ans = ans;
            end
            if (!busy) break;
            wdata = $urandom;
            op    = 1'($urandom_range(0, 1));
        end
        check("held_start_one_done", dones, 1);
        check("held_start_first_result", first_ans, 32'd36);
        check("held_start_busy_fall_cycle", cyc, 40);
        op    = 1'b0;
        wdata = 32'h0030_0024;
        @(negedge clk);
        start = 1'b0;
        check("next_cmd_accepted_busy", {31'd0, busy}, 32'd1);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        check("next_cmd_done_seen", {31'd0, lat > 0}, 32'd1);
        check("next_cmd_ans", ans, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
